// File: rtl/proj_buffer_writer.sv
// Write-side controller for the projection FM buffer: fills one frame from a
// valid/ready stream, launches the reader, then waits for its completion edge.
module proj_buffer_writer #(
    parameter int FM_BUFFER_SIZE = 8,
    parameter int DATA_W         = 32,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    input  logic [DATA_W-1:0]         in_data_i,
    output logic                      in_ready_o,
    input  logic                      flush_i,
    output logic                      wr_en_o,
    output logic [FM_BUFFER_SIZE-1:0] wr_addr_o,
    output logic [DATA_W-1:0]         wr_data_o,
    output logic                      proj_start_o,
    input  logic                      proj_done_i,
    output logic [FRAME_CNT_W-1:0]    frame_cnt_o
);

    localparam int PTR_W = (FM_BUFFER_SIZE > 1) ? $clog2(FM_BUFFER_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic                      done_prev_q;
    logic                      in_ready_q, in_ready_d;
    logic                      wr_en_q, wr_en_d;
    logic [FM_BUFFER_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]         wr_data_q, wr_data_d;
    logic                      proj_start_q, proj_start_d;
    logic [FRAME_CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

    logic accept;
    logic done_rise;
    logic ptr_last;

    // in_ready_q mirrors (state_q == FILL), so it doubles as the FILL qualifier.
    assign accept    = in_valid_i & in_ready_q;
    assign done_rise = proj_done_i & ~done_prev_q;
    assign ptr_last  = (wr_ptr_q == PTR_W'(FM_BUFFER_SIZE - 1));

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        frame_cnt_d = frame_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        case (state_q)
            IDLE: state_d = FILL;
            FILL: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = FM_BUFFER_SIZE'(wr_ptr_q);
                    wr_data_d = in_data_i;
                    if (ptr_last) begin
                        wr_ptr_d = '0;
                        state_d  = START;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            START: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (done_rise) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = FILL;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides everything decided above, including a pending launch.
        if (flush_i && (state_q != IDLE)) begin
            state_d     = FILL;
            wr_ptr_d    = '0;
            frame_cnt_d = frame_cnt_q;
            wr_en_d     = 1'b0;
            wr_addr_d   = wr_addr_q;
            wr_data_d   = wr_data_q;
        end

        in_ready_d   = (state_d == FILL);
        proj_start_d = (state_d == START);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            done_prev_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            proj_start_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            done_prev_q  <= proj_done_i;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            proj_start_q <= proj_start_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign proj_start_o = proj_start_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_proj_buffer_writer.sv
// Scoreboard bench for proj_buffer_writer: accepted beats are queued with their
// expected address and checked against the write port one cycle later.
module tb_proj_buffer_writer;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic          wr_en;
    logic [N-1:0]  wr_addr;
    logic [DW-1:0] wr_data;
    logic          proj_start;
    logic          proj_done = 1'b0;
    logic [FW-1:0] frame_cnt;

    proj_buffer_writer #(.FM_BUFFER_SIZE(N), .DATA_W(DW), .FRAME_CNT_W(FW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .flush_i      (flush),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .proj_start_o (proj_start),
        .proj_done_i  (proj_done),
        .frame_cnt_o  (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: 0 idle, 1 fill, 2 start, 3 wait_done
    int            m_state;
    int            m_ptr;
    logic [FW-1:0] m_frame;
    logic          m_prev;
    logic          m_ready;
    logic [N+DW-1:0] sb_q[$];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_in_ready"},   64'(in_ready),   64'd0);
        check_val({tag, "_wr_en"},      64'(wr_en),      64'd0);
        check_val({tag, "_wr_addr"},    64'(wr_addr),    64'd0);
        check_val({tag, "_wr_data"},    64'(wr_data),    64'd0);
        check_val({tag, "_proj_start"}, 64'(proj_start), 64'd0);
        check_val({tag, "_frame_cnt"},  64'(frame_cnt),  64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        proj_done = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        m_state = 0;
        m_ptr   = 0;
        m_frame = '0;
        m_prev  = 1'b0;
        m_ready = 1'b0;
        sb_q.delete();
        rst = 1'b0;
        $display("reset released");
    endtask

    // One clock of stimulus followed by checking of every registered output.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic fl, input logic dn);
        logic acc;
        logic rise;
        logic [N+DW-1:0] item;
        in_valid  = v;
        in_data   = d;
        flush     = fl;
        proj_done = dn;
        check_val("in_ready", 64'(in_ready), 64'(m_ready));
        acc  = v & m_ready & ~fl;
        rise = dn & ~m_prev;
        if (acc) sb_q.push_back({N'(m_ptr), d});
        case (m_state)
            0: m_state = 1;
            1: if (acc) begin
                   if (m_ptr == N - 1) begin
                       m_ptr   = 0;
                       m_state = 2;
                   end else begin
                       m_ptr++;
                   end
               end
            2: m_state = 3;
            default: if (rise && !fl) begin
                   m_frame++;
                   m_state = 1;
               end
        endcase
        if (fl && m_state != 0) begin
            m_state = 1;
            m_ptr   = 0;
        end
        m_prev  = dn;
        m_ready = (m_state == 1);

        @(posedge clk);
        #1;
        check_val("wr_en", 64'(wr_en), 64'(acc));
        if (wr_en) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_write", 64'(wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                item = sb_q.pop_front();
                $display("write addr=%0d data=0x%08h (expected addr=%0d data=0x%08h)",
                         wr_addr, wr_data, item[N+DW-1:DW], item[DW-1:0]);
                check_val("wr_addr", 64'(wr_addr), 64'(item[N+DW-1:DW]));
                check_val("wr_data", 64'(wr_data), 64'(item[DW-1:0]));
            end
        end
        check_val("proj_start", 64'(proj_start), 64'(m_state == 2));
        check_val("frame_cnt",  64'(frame_cnt),  64'(m_frame));
    endtask

    initial begin
        int accepts;
        int steps;
        logic [4:0] pat;

        // Reset and release: in_ready low one cycle, then high
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check_val("ready_after_idle", 64'(in_ready), 64'd1);

        // Continuous fill 0x10..0x17
        for (int i = 0; i < N; i++) step(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
        check_val("start_pulse", 64'(proj_start), 64'd1);
        check_val("start_addr7", 64'(wr_addr), 64'd7);
        check_val("start_data17", 64'(wr_data), 64'h17);

        // Done held high from entry into WAIT_DONE is ignored
        for (int i = 0; i < 4; i++) step(1'b1, 32'hDEAD_0000 + 32'(i), 1'b0, 1'b1);
        check_val("done_level_ignored", 64'(frame_cnt), 64'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_val("frame_after_edge", 64'(frame_cnt), 64'd1);
        check_val("ready_after_edge", 64'(in_ready), 64'd1);

        // Gapped input 1,0,1,1,0 repeating
        pat = 5'b01101;
        accepts = 0;
        steps = 0;
        while (accepts < N && steps < 60) begin
            if (pat[steps % 5]) begin
                step(1'b1, $urandom, 1'b0, 1'b0);
                accepts++;
            end else begin
                step(1'b0, $urandom, 1'b0, 1'b0);
            end
            steps++;
        end
        check_val("gapped_accepts", 64'(accepts), 64'(N));
        check_val("gapped_start", 64'(proj_start), 64'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_val("frame_after_gapped", 64'(frame_cnt), 64'd2);

        // Flush after three accepts
        for (int i = 0; i < 3; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'hBAD0, 1'b1, 1'b0);
        check_val("flush_frame", 64'(frame_cnt), 64'd2);
        for (int i = 0; i < N - 1; i++) begin
            step(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
            if (i == 0) check_val("flush_restart_addr0", 64'(wr_addr), 64'd0);
        end
        check_val("flush_no_early_start", 64'(proj_start), 64'd0);
        step(1'b1, 32'hC7, 1'b0, 1'b0);
        check_val("flush_full_frame_start", 64'(proj_start), 64'd1);
        // Flush beats a simultaneous done edge in WAIT_DONE
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check_val("flush_over_done", 64'(frame_cnt), 64'd2);
        check_val("flush_ready", 64'(in_ready), 64'd1);

        // Reset pulse mid-fill after five accepts
        for (int i = 0; i < 5; i++) step(1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0);
        #3;
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            step(1'b1, 32'hF0 + 32'(i), 1'b0, 1'b0);
            if (i == 0) check_val("refill_addr0", 64'(wr_addr), 64'd0);
        end
        check_val("refill_start", 64'(proj_start), 64'd1);
        check_val("refill_frame0", 64'(frame_cnt), 64'd0);
        check_val("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
